// File: rtl/cache_pkg.sv
// Shared constants and sweep-FSM state type for the two-way L1 cache store.
package cache_pkg;

   localparam int unsigned LINE_WIDTH_DEF = 32;
   localparam int unsigned TAG_BITS_DEF   = 21;
   localparam int unsigned INDEX_BITS_DEF = 9;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_e;

endpackage

// File: rtl/l1_way_array.sv
// One cache way: data, tag, valid and dirty arrays with a single-set clear port.
module l1_way_array #(
   parameter int unsigned LINE_WIDTH = 32,
   parameter int unsigned TAG_BITS   = 21,
   parameter int unsigned INDEX_BITS = 9
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [INDEX_BITS-1:0] widx_i,
   input  logic [LINE_WIDTH-1:0] wdata_i,
   input  logic [TAG_BITS-1:0]   wtag_i,
   input  logic                  wvalid_i,
   input  logic                  wdirty_i,
   input  logic                  clr_i,
   input  logic [INDEX_BITS-1:0] clr_idx_i,
   input  logic [INDEX_BITS-1:0] ridx_i,
   output logic [LINE_WIDTH-1:0] data_o,
   output logic [TAG_BITS-1:0]   tag_o,
   output logic                  valid_o,
   output logic                  dirty_o
);

   localparam int unsigned SETS = 2**INDEX_BITS;

   logic [LINE_WIDTH-1:0] data_q  [SETS];
   logic [TAG_BITS-1:0]   tag_q   [SETS];
   logic                  valid_q [SETS];
   logic                  dirty_q [SETS];

   // Tag and data are never cleared; a flush only drops valid/dirty.
   always_ff @(posedge clk) begin
      if (we_i) begin
         data_q[widx_i] <= wdata_i;
         tag_q[widx_i]  <= wtag_i;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         valid_q[clr_idx_i] <= 1'b0;
         dirty_q[clr_idx_i] <= 1'b0;
      end else if (we_i) begin
         valid_q[widx_i] <= wvalid_i;
         dirty_q[widx_i] <= wdirty_i;
      end
   end

   assign data_o  = data_q[ridx_i];
   assign tag_o   = tag_q[ridx_i];
   assign valid_o = valid_q[ridx_i];
   assign dirty_o = dirty_q[ridx_i];

endmodule

// File: rtl/l1_cache_store.sv
// Two-way L1 storage with per-set LRU bit and a set-by-set invalidation sweep.
module l1_cache_store
   import cache_pkg::*;
#(
   parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int unsigned TAG_BITS   = TAG_BITS_DEF,
   parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_req,
   output logic                  busy,
   input  logic [INDEX_BITS-1:0] L1_read_index,
   output logic [LINE_WIDTH-1:0] L1_data_way0,
   output logic [LINE_WIDTH-1:0] L1_data_way1,
   output logic [TAG_BITS-1:0]   L1_tag_way0,
   output logic [TAG_BITS-1:0]   L1_tag_way1,
   output logic                  L1_valid_way0,
   output logic                  L1_valid_way1,
   output logic                  L1_dirty_way0,
   output logic                  L1_dirty_way1,
   output logic                  L1_lru_bit,
   input  logic                  L1_write_en_way0,
   input  logic                  L1_write_en_way1,
   input  logic [INDEX_BITS-1:0] L1_write_index,
   input  logic [LINE_WIDTH-1:0] L1_write_data_way0,
   input  logic [LINE_WIDTH-1:0] L1_write_data_way1,
   input  logic [TAG_BITS-1:0]   L1_write_tag_way0,
   input  logic [TAG_BITS-1:0]   L1_write_tag_way1,
   input  logic                  L1_write_valid_way0,
   input  logic                  L1_write_valid_way1,
   input  logic                  L1_write_dirty_way0,
   input  logic                  L1_write_dirty_way1,
   input  logic                  L1_write_lru,
   input  logic                  L1_lru_value
);

   localparam int unsigned SETS = 2**INDEX_BITS;

   state_e                state_q, state_d;
   logic [INDEX_BITS-1:0] cnt_q, cnt_d;
   logic                  lru_q [SETS];
   logic                  valid0, valid1, dirty0, dirty1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (flush_req) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end
         end
         SWEEP: begin
            cnt_d = cnt_q + INDEX_BITS'(1);
            if (cnt_q == {INDEX_BITS{1'b1}}) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SWEEP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == SWEEP);

   always_ff @(posedge clk) begin
      if (busy) begin
         lru_q[cnt_q] <= 1'b0;
      end else if (L1_write_lru) begin
         lru_q[L1_write_index] <= L1_lru_value;
      end
   end

   l1_way_array #(
      .LINE_WIDTH (LINE_WIDTH),
      .TAG_BITS   (TAG_BITS),
      .INDEX_BITS (INDEX_BITS)
   ) u_way0 (
      .clk       (clk),
      .we_i      (L1_write_en_way0 & ~busy),
      .widx_i    (L1_write_index),
      .wdata_i   (L1_write_data_way0),
      .wtag_i    (L1_write_tag_way0),
      .wvalid_i  (L1_write_valid_way0),
      .wdirty_i  (L1_write_dirty_way0),
      .clr_i     (busy),
      .clr_idx_i (cnt_q),
      .ridx_i    (L1_read_index),
      .data_o    (L1_data_way0),
      .tag_o     (L1_tag_way0),
      .valid_o   (valid0),
      .dirty_o   (dirty0)
   );

   l1_way_array #(
      .LINE_WIDTH (LINE_WIDTH),
      .TAG_BITS   (TAG_BITS),
      .INDEX_BITS (INDEX_BITS)
   ) u_way1 (
      .clk       (clk),
      .we_i      (L1_write_en_way1 & ~busy),
      .widx_i    (L1_write_index),
      .wdata_i   (L1_write_data_way1),
      .wtag_i    (L1_write_tag_way1),
      .wvalid_i  (L1_write_valid_way1),
      .wdirty_i  (L1_write_dirty_way1),
      .clr_i     (busy),
      .clr_idx_i (cnt_q),
      .ridx_i    (L1_read_index),
      .data_o    (L1_data_way1),
      .tag_o     (L1_tag_way1),
      .valid_o   (valid1),
      .dirty_o   (dirty1)
   );

   // Sets not yet swept still hold stale bits, so hide them for the whole sweep.
   assign L1_valid_way0 = valid0 & ~busy;
   assign L1_valid_way1 = valid1 & ~busy;
   assign L1_dirty_way0 = dirty0 & ~busy;
   assign L1_dirty_way1 = dirty1 & ~busy;
   assign L1_lru_bit    = lru_q[L1_read_index];

endmodule

// File: tb/tb_l1_cache_store.sv
// Directed bench for l1_cache_store: reset sweep, writes, LRU, flush and reset mid-flush.
module tb_l1_cache_store;

   localparam int unsigned LW = 32;
   localparam int unsigned TB = 21;
   localparam int unsigned IB = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_req;
   logic          busy;
   logic [IB-1:0] L1_read_index;
   logic [LW-1:0] L1_data_way0, L1_data_way1;
   logic [TB-1:0] L1_tag_way0, L1_tag_way1;
   logic          L1_valid_way0, L1_valid_way1, L1_dirty_way0, L1_dirty_way1, L1_lru_bit;
   logic          L1_write_en_way0, L1_write_en_way1;
   logic [IB-1:0] L1_write_index;
   logic [LW-1:0] L1_write_data_way0, L1_write_data_way1;
   logic [TB-1:0] L1_write_tag_way0, L1_write_tag_way1;
   logic          L1_write_valid_way0, L1_write_valid_way1;
   logic          L1_write_dirty_way0, L1_write_dirty_way1;
   logic          L1_write_lru, L1_lru_value;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   l1_cache_store dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush_req           (flush_req),
      .busy                (busy),
      .L1_read_index       (L1_read_index),
      .L1_data_way0        (L1_data_way0),
      .L1_data_way1        (L1_data_way1),
      .L1_tag_way0         (L1_tag_way0),
      .L1_tag_way1         (L1_tag_way1),
      .L1_valid_way0       (L1_valid_way0),
      .L1_valid_way1       (L1_valid_way1),
      .L1_dirty_way0       (L1_dirty_way0),
      .L1_dirty_way1       (L1_dirty_way1),
      .L1_lru_bit          (L1_lru_bit),
      .L1_write_en_way0    (L1_write_en_way0),
      .L1_write_en_way1    (L1_write_en_way1),
      .L1_write_index      (L1_write_index),
      .L1_write_data_way0  (L1_write_data_way0),
      .L1_write_data_way1  (L1_write_data_way1),
      .L1_write_tag_way0   (L1_write_tag_way0),
      .L1_write_tag_way1   (L1_write_tag_way1),
      .L1_write_valid_way0 (L1_write_valid_way0),
      .L1_write_valid_way1 (L1_write_valid_way1),
      .L1_write_dirty_way0 (L1_write_dirty_way0),
      .L1_write_dirty_way1 (L1_write_dirty_way1),
      .L1_write_lru        (L1_write_lru),
      .L1_lru_value        (L1_lru_value)
   );

   task automatic idle_inputs();
      flush_req           = 1'b0;
      L1_write_en_way0    = 1'b0;
      L1_write_en_way1    = 1'b0;
      L1_write_lru        = 1'b0;
      L1_lru_value        = 1'b0;
      L1_write_index      = '0;
      L1_write_data_way0  = '0;
      L1_write_data_way1  = '0;
      L1_write_tag_way0   = '0;
      L1_write_tag_way1   = '0;
      L1_write_valid_way0 = 1'b0;
      L1_write_valid_way1 = 1'b0;
      L1_write_dirty_way0 = 1'b0;
      L1_write_dirty_way1 = 1'b0;
   endtask

   // Samples #1 after each posedge; returns how many consecutive samples showed busy=1.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      idle_inputs();
      L1_read_index = '0;
      @(posedge clk); #1;
      n_total++;
      if (busy !== 1'b1) $display("FAIL reset_busy_during_rst: got %b want 1", busy);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      count_busy(n);
      n_total++;
      if (n + 1 !== 512) $display("FAIL reset_busy_len: got %0d want 512", n + 1);
      else n_pass++;
      L1_read_index = 9'h1FF;
      #1;
      n_total++;
      if ({L1_valid_way0, L1_valid_way1, L1_dirty_way0, L1_dirty_way1, L1_lru_bit} !== 5'b0)
         $display("FAIL reset_1ff_meta: got %b want 00000",
                  {L1_valid_way0, L1_valid_way1, L1_dirty_way0, L1_dirty_way1, L1_lru_bit});
      else n_pass++;
   endtask

   task automatic test_write_readback();
      @(negedge clk);
      L1_write_index      = 9'h05;
      L1_write_en_way1    = 1'b1;
      L1_write_tag_way1   = 21'h00111;
      L1_write_data_way1  = 32'h1111_1111;
      L1_write_valid_way1 = 1'b1;
      L1_write_dirty_way1 = 1'b0;
      @(negedge clk);
      L1_write_tag_way1   = 21'h1ABCD;
      L1_write_data_way1  = 32'hDEAD_BEEF;
      L1_write_dirty_way1 = 1'b1;
      L1_read_index       = 9'h05;
      #1;
      n_total++;
      if ({L1_tag_way1, L1_data_way1, L1_dirty_way1} !== {21'h00111, 32'h1111_1111, 1'b0})
         $display("FAIL wr_same_cycle_old: got tag %h data %h dirty %b want 00111 11111111 0",
                  L1_tag_way1, L1_data_way1, L1_dirty_way1);
      else n_pass++;
      @(posedge clk); #1;
      idle_inputs();
      #1;
      n_total++;
      if (L1_tag_way1 !== 21'h1ABCD) $display("FAIL wr_tag1: got %h want 1abcd", L1_tag_way1);
      else n_pass++;
      n_total++;
      if (L1_data_way1 !== 32'hDEAD_BEEF)
         $display("FAIL wr_data1: got %h want deadbeef", L1_data_way1);
      else n_pass++;
      n_total++;
      if ({L1_valid_way1, L1_dirty_way1} !== 2'b11)
         $display("FAIL wr_vd1: got %b want 11", {L1_valid_way1, L1_dirty_way1});
      else n_pass++;
      n_total++;
      if ({L1_valid_way0, L1_dirty_way0} !== 2'b00)
         $display("FAIL wr_way0_untouched: got %b want 00", {L1_valid_way0, L1_dirty_way0});
      else n_pass++;
   endtask

   task automatic test_dual_write_lru();
      @(negedge clk);
      L1_write_index      = 9'h10;
      L1_write_en_way0    = 1'b1;
      L1_write_en_way1    = 1'b1;
      L1_write_tag_way0   = 21'h00A0A;
      L1_write_data_way0  = 32'hCAFE_F00D;
      L1_write_valid_way0 = 1'b1;
      L1_write_dirty_way0 = 1'b0;
      L1_write_tag_way1   = 21'h15555;
      L1_write_data_way1  = 32'h1234_5678;
      L1_write_valid_way1 = 1'b1;
      L1_write_dirty_way1 = 1'b1;
      L1_write_lru        = 1'b1;
      L1_lru_value        = 1'b1;
      L1_read_index       = 9'h10;
      #1;
      n_total++;
      if (L1_lru_bit !== 1'b0) $display("FAIL dual_lru_pre: got %b want 0", L1_lru_bit);
      else n_pass++;
      @(posedge clk); #1;
      idle_inputs();
      #1;
      n_total++;
      if ({L1_tag_way0, L1_data_way0, L1_valid_way0, L1_dirty_way0}
          !== {21'h00A0A, 32'hCAFE_F00D, 1'b1, 1'b0})
         $display("FAIL dual_way0: got %h %h %b%b want 00a0a cafef00d 10",
                  L1_tag_way0, L1_data_way0, L1_valid_way0, L1_dirty_way0);
      else n_pass++;
      n_total++;
      if ({L1_tag_way1, L1_data_way1, L1_valid_way1, L1_dirty_way1}
          !== {21'h15555, 32'h1234_5678, 1'b1, 1'b1})
         $display("FAIL dual_way1: got %h %h %b%b want 15555 12345678 11",
                  L1_tag_way1, L1_data_way1, L1_valid_way1, L1_dirty_way1);
      else n_pass++;
      n_total++;
      if (L1_lru_bit !== 1'b1) $display("FAIL dual_lru: got %b want 1", L1_lru_bit);
      else n_pass++;
      // LRU-only update leaves the ways alone.
      @(negedge clk);
      L1_write_index = 9'h10;
      L1_write_lru   = 1'b1;
      L1_lru_value   = 1'b0;
      @(posedge clk); #1;
      idle_inputs();
      #1;
      n_total++;
      if ({L1_lru_bit, L1_tag_way0, L1_valid_way1} !== {1'b0, 21'h00A0A, 1'b1})
         $display("FAIL lru_only: got lru %b tag0 %h v1 %b want 0 00a0a 1",
                  L1_lru_bit, L1_tag_way0, L1_valid_way1);
      else n_pass++;
   endtask

   task automatic test_flush();
      int n;
      @(negedge clk);
      L1_write_index      = 9'h20;
      L1_write_en_way0    = 1'b1;
      L1_write_en_way1    = 1'b1;
      L1_write_tag_way0   = 21'h0F0F0;
      L1_write_data_way0  = 32'h5A5A_5A5A;
      L1_write_tag_way1   = 21'h0F0F1;
      L1_write_data_way1  = 32'hA5A5_A5A5;
      L1_write_valid_way0 = 1'b1;
      L1_write_valid_way1 = 1'b1;
      L1_write_dirty_way0 = 1'b1;
      L1_write_dirty_way1 = 1'b1;
      L1_write_lru        = 1'b1;
      L1_lru_value        = 1'b1;
      L1_read_index       = 9'h20;
      @(negedge clk);
      idle_inputs();
      #1;
      n_total++;
      if ({L1_valid_way0, L1_valid_way1, L1_dirty_way0, L1_dirty_way1, L1_lru_bit} !== 5'b11111)
         $display("FAIL flush_fill: got %b want 11111",
                  {L1_valid_way0, L1_valid_way1, L1_dirty_way0, L1_dirty_way1, L1_lru_bit});
      else n_pass++;
      @(negedge clk);
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      // Write attempt while busy must be dropped.
      L1_write_index      = 9'h20;
      L1_write_en_way0    = 1'b1;
      L1_write_tag_way0   = 21'h1FFFF;
      L1_write_data_way0  = 32'h0;
      L1_write_valid_way0 = 1'b1;
      L1_write_dirty_way0 = 1'b1;
      #1;
      n_total++;
      if ({busy, L1_valid_way0, L1_dirty_way1} !== 3'b100)
         $display("FAIL flush_busy_masked: got busy/v0/d1 %b want 100",
                  {busy, L1_valid_way0, L1_dirty_way1});
      else n_pass++;
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         n++;
         if (n == 4) idle_inputs();
         if (n == 512) flush_req = 1'b1;   // request in final sweep cycle: ignored
         @(posedge clk); #1;
         if (n == 512) flush_req = 1'b0;
      end
      idle_inputs();
      n_total++;
      if (n !== 512) $display("FAIL flush_busy_len: got %0d want 512", n);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (busy !== 1'b0) $display("FAIL flush_no_back_to_back: got busy %b want 0", busy);
      else n_pass++;
      n_total++;
      if ({L1_valid_way0, L1_valid_way1, L1_dirty_way0, L1_dirty_way1, L1_lru_bit} !== 5'b0)
         $display("FAIL flush_meta_cleared: got %b want 00000",
                  {L1_valid_way0, L1_valid_way1, L1_dirty_way0, L1_dirty_way1, L1_lru_bit});
      else n_pass++;
      n_total++;
      if ({L1_tag_way0, L1_data_way0, L1_tag_way1, L1_data_way1}
          !== {21'h0F0F0, 32'h5A5A_5A5A, 21'h0F0F1, 32'hA5A5_A5A5})
         $display("FAIL flush_tag_data_kept: got %h %h %h %h want 0f0f0 5a5a5a5a 0f0f1 a5a5a5a5",
                  L1_tag_way0, L1_data_way0, L1_tag_way1, L1_data_way1);
      else n_pass++;
   endtask

   task automatic test_reset_mid_flush();
      int n;
      @(negedge clk);
      L1_write_index      = 9'h1F0;
      L1_write_en_way1    = 1'b1;
      L1_write_tag_way1   = 21'h00042;
      L1_write_valid_way1 = 1'b1;
      L1_write_dirty_way1 = 1'b1;
      @(negedge clk);
      idle_inputs();
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      n = 1;
      while (n < 300 && busy === 1'b1) begin
         @(posedge clk); #1;
         n++;
      end
      n_total++;
      if (busy !== 1'b1 || n !== 300)
         $display("FAIL midflush_reach_300: got busy %b at cycle %0d want 1 at 300", busy, n);
      else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      count_busy(n);
      n_total++;
      if (n + 1 !== 512) $display("FAIL midflush_busy_len: got %0d want 512", n + 1);
      else n_pass++;
      L1_read_index = 9'h1F0;
      #1;
      n_total++;
      if ({L1_valid_way1, L1_dirty_way1, L1_tag_way1} !== {1'b0, 1'b0, 21'h00042})
         $display("FAIL midflush_1f0: got v %b d %b tag %h want 0 0 00042",
                  L1_valid_way1, L1_dirty_way1, L1_tag_way1);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_readback();
      test_dual_write_lru();
      test_flush();
      test_reset_mid_flush();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/l1_cache_store.md
L1_CACHE_STORE -- requirements
Module: l1_cache_store

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 32, data bits per line (one word).
REQ-002 SHALL have parameter TAG_BITS, default 21, tag width.
REQ-003 SHALL have parameter INDEX_BITS, default 9, set index width; SETS = 2**INDEX_BITS.
REQ-004 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_req  in  1  request to invalidate all sets.
REQ-007 SHALL have port busy  out  1  sweep in progress; the requester stalls while high.
REQ-008 SHALL have port L1_read_index  in  INDEX_BITS  read set.
REQ-009 SHALL have ports L1_data_way0/1  out  LINE_WIDTH each  line data of the read set.
REQ-010 SHALL have ports L1_tag_way0/1, L1_valid_way0/1, L1_dirty_way0/1  out  TAG_BITS/1/1 each  metadata of the read set.
REQ-011 SHALL have port L1_lru_bit  out  1  LRU way of the read set.
REQ-012 SHALL have ports L1_write_en_way0/1  in  1 each  per-way line write strobes.
REQ-013 SHALL have port L1_write_index  in  INDEX_BITS  write set.
REQ-014 SHALL have ports L1_write_data/tag/valid/dirty_way0/1  in  LINE_WIDTH/TAG_BITS/1/1  write payload per way.
REQ-015 SHALL have ports L1_write_lru, L1_lru_value  in  1 each  LRU update strobe and value.

Function
REQ-016 Read outputs SHALL be combinational from current array contents at L1_read_index, with zero latency.
REQ-017 A write SHALL take effect at the posedge; a read of the same set in the write cycle SHALL return the pre-write contents.
REQ-018 L1_write_en_way0 and L1_write_en_way1 SHALL act independently; both asserted in one cycle updates both ways.
REQ-019 L1_write_lru SHALL update only the LRU bit of L1_write_index, independent of the way strobes, and in the same cycle as them.
REQ-020 The FSM states SHALL be IDLE and SWEEP; an INDEX_BITS-wide sweep counter selects the set being cleared.
REQ-021 In IDLE with flush_req=1, the next state SHALL be SWEEP with the counter at 0.
REQ-022 Each SWEEP cycle SHALL clear valid, dirty and lru of both ways at the counter set, then increment the counter.
REQ-023 SWEEP SHALL return to IDLE after the cycle that clears set SETS-1; the counter wraps to 0 and a sweep lasts exactly SETS cycles.
REQ-024 busy SHALL be 1 exactly while the state is SWEEP.
REQ-025 While busy=1, all write strobes and flush_req SHALL be ignored, and valid/dirty outputs SHALL read 0.
REQ-026 Tag and data arrays SHALL never be cleared; only valid/dirty/lru are cleared.
REQ-027 flush_req asserted in the last SWEEP cycle SHALL be ignored; no back-to-back sweep starts without a fresh request in IDLE.

Reset
REQ-028 rst=1 SHALL force state SWEEP with the counter at 0, so busy=1 in the cycle after rst is sampled.
REQ-029 rst held for N cycles SHALL keep the counter at 0; the SETS-cycle sweep begins on the first cycle after rst deasserts.
REQ-030 rst asserted mid-sweep SHALL restart the sweep from set 0.
REQ-031 After the post-reset sweep, every set SHALL read valid=0, dirty=0, lru=0.

Structure
REQ-032 A shared package cache_pkg SHALL hold the default LINE_WIDTH/TAG_BITS/INDEX_BITS constants and the IDLE/SWEEP state enum.
REQ-033 One sub-module l1_way_array (data, tag, valid and dirty for a single way, with a clear port) SHALL be instantiated twice.
REQ-034 The LRU bit array and the sweep FSM SHALL reside in l1_cache_store.

Verification
REQ-035 Reset: rst for 2 cycles, then release -> busy=1 for exactly 512 cycles, then 0; index 0x1FF reads valid0=valid1=0.
REQ-036 Write/read-back: write way1 at index 0x05 (tag 0x1ABCD, data 0xDEADBEEF, valid=1, dirty=1) -> same-cycle read of 0x05 shows old contents; next cycle shows the new values, and way0 is unchanged.
REQ-037 Dual write plus LRU: both way strobes and L1_write_lru=1 with lru_value=1 at index 0x10 -> both ways and lru=1 visible the next cycle.
REQ-038 Flush: fill index 0x20 valid/dirty, assert flush_req for 1 cycle -> busy for 512 cycles; during busy a write to 0x20 is dropped; afterwards 0x20 reads valid=0, dirty=0, and its tag/data are retained.
REQ-039 Reset mid-flush: assert rst at sweep cycle 300 -> sweep restarts, and busy falls exactly 512 cycles after rst deasserts.
